// File: rtl/pmod_ad1_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pmod_ad1_reader
//
// Serial-capture master for the dual-channel 12-bit PmodAD1 ADC (two
// AD7476A-class converters sharing CS and SCLK). One start request produces
// one CS-low frame of 16 SCLK periods. Both data lines are shifted in MSB
// first, and the two 12-bit samples are then presented with a one-cycle
// valid strobe. The busy flag stays high through the converter quiet time.
//
// Optional feature: define PMOD_AD1_LEADZERO_CHECK_EN to build the
// leading-zero check. The four leading frame bits of both channels must be 0;
// if any is 1, o_err is set together with o_valid. Without the macro, no check
// logic is built and o_err is tied to 0.
//
// Parameters
//   CLK_DIV    SCLK half-period in i_clk cycles (2..255)
//   QUIET_CYC  minimum cycles busy stays high after CS rises (1..255)
//
// Ports
//   i_clk                       system clock, rising edge
//   i_rst                       synchronous active-high reset
//   i_start                     conversion request, sampled only in IDLE
//   i_sdata_a, i_sdata_b        serial data from ADC channels A and B
//   o_cs                        chip select, active low
//   o_sclk                      serial clock, idles high
//   o_data_out_a, o_data_out_b  last captured 12-bit samples
//   o_valid                     one-cycle strobe when the samples update
//   o_busy                      conversion or quiet time in progress
//   o_err                       leading-zero violation flag
// -----------------------------------------------------------------------------
module pmod_ad1_reader #(
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_sdata_a,
    input  logic        i_sdata_b,
    output logic        o_cs,
    output logic        o_sclk,
    output logic [11:0] o_data_out_a,
    output logic [11:0] o_data_out_b,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_QUIET
    } state_t;

    // The shift registers only have to hold the leading-zero bits when those
    // bits are checked. Otherwise the leading zeros simply fall off the top of
    // a 12-bit register during the 16 shifts.
`ifdef PMOD_AD1_LEADZERO_CHECK_EN
    localparam int SHIFT_W = 16;
`else
    localparam int SHIFT_W = 12;
`endif

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYC - 1);
    localparam logic [4:0] BITS_LAST  = 5'd16;

    state_t               r_state,      w_state;
    logic [7:0]           r_div,        w_div;
    logic [4:0]           r_bit_cnt,    w_bit_cnt;
    logic [7:0]           r_quiet_cnt,  w_quiet_cnt;
    logic [SHIFT_W-1:0]   r_shift_a,    w_shift_a;
    logic [SHIFT_W-1:0]   r_shift_b,    w_shift_b;
    logic                 r_cs,         w_cs;
    logic                 r_sclk,       w_sclk;
    logic [11:0]          r_data_a,     w_data_a;
    logic [11:0]          r_data_b,     w_data_b;
    logic                 r_valid,      w_valid;
    logic                 r_busy,       w_busy;
`ifdef PMOD_AD1_LEADZERO_CHECK_EN
    logic                 r_err,        w_err;
`endif

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default first (hold, or 0 for the strobe),
        // so no path through the case statement can infer a latch.
        w_state     = r_state;
        w_div       = r_div;
        w_bit_cnt   = r_bit_cnt;
        w_quiet_cnt = r_quiet_cnt;
        w_shift_a   = r_shift_a;
        w_shift_b   = r_shift_b;
        w_cs        = r_cs;
        w_sclk      = r_sclk;
        w_data_a    = r_data_a;
        w_data_b    = r_data_b;
        w_valid     = 1'b0;
        w_busy      = r_busy;
`ifdef PMOD_AD1_LEADZERO_CHECK_EN
        w_err       = r_err;
`endif

        case (r_state)
            ST_IDLE: begin
                w_cs   = 1'b1;
                w_sclk = 1'b1;
                w_busy = 1'b0;
                if (i_start) begin
                    w_state   = ST_SHIFT;
                    w_cs      = 1'b0;
                    w_busy    = 1'b1;
                    w_bit_cnt = 5'd0;
                    w_div     = 8'd0;
                end
            end

            ST_SHIFT: begin
                if (r_bit_cnt == BITS_LAST) begin
                    // SCLK has been parked high for one extra cycle after the
                    // 16th rise; close the frame and publish both samples.
                    w_state     = ST_QUIET;
                    w_cs        = 1'b1;
                    w_sclk      = 1'b1;
                    w_valid     = 1'b1;
                    w_quiet_cnt = 8'd0;
                    w_data_a    = r_shift_a[11:0];
                    w_data_b    = r_shift_b[11:0];
`ifdef PMOD_AD1_LEADZERO_CHECK_EN
                    w_err = (|r_shift_a[15:12]) | (|r_shift_b[15:12]);
`endif
                end else if (r_div == DIV_LAST) begin
                    w_div  = 8'd0;
                    w_sclk = ~r_sclk;
                    // A low SCLK here means this edge drives it 0->1. The data
                    // have been stable for a full half-period, so sample them now.
                    if (!r_sclk) begin
                        w_shift_a = {r_shift_a[SHIFT_W-2:0], i_sdata_a};
                        w_shift_b = {r_shift_b[SHIFT_W-2:0], i_sdata_b};
                        w_bit_cnt = r_bit_cnt + 5'd1;
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end

            ST_QUIET: begin
                if (r_quiet_cnt == QUIET_LAST) begin
                    w_state = ST_IDLE;
                    w_busy  = 1'b0;
                end else begin
                    w_quiet_cnt = r_quiet_cnt + 8'd1;
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_cs    = 1'b1;
                w_sclk  = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State register. Reset wins in every state and discards any frame in flight.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of all the others.
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_div       <= 8'd0;
            r_bit_cnt   <= 5'd0;
            r_quiet_cnt <= 8'd0;
            r_shift_a   <= '0;
            r_shift_b   <= '0;
            r_cs        <= 1'b1;
            r_sclk      <= 1'b1;
            r_data_a    <= 12'd0;
            r_data_b    <= 12'd0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef PMOD_AD1_LEADZERO_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state;
            r_div       <= w_div;
            r_bit_cnt   <= w_bit_cnt;
            r_quiet_cnt <= w_quiet_cnt;
            r_shift_a   <= w_shift_a;
            r_shift_b   <= w_shift_b;
            r_cs        <= w_cs;
            r_sclk      <= w_sclk;
            r_data_a    <= w_data_a;
            r_data_b    <= w_data_b;
            r_valid     <= w_valid;
            r_busy      <= w_busy;
`ifdef PMOD_AD1_LEADZERO_CHECK_EN
            r_err       <= w_err;
`endif
        end
    end

    assign o_cs         = r_cs;
    assign o_sclk       = r_sclk;
    assign o_data_out_a = r_data_a;
    assign o_data_out_b = r_data_b;
    assign o_valid      = r_valid;
    assign o_busy       = r_busy;
`ifdef PMOD_AD1_LEADZERO_CHECK_EN
    assign o_err        = r_err;
`else
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_pmod_ad1_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pmod_ad1_reader
//
// Self-checking bench for pmod_ad1_reader with default parameters. A
// behavioural ADC model shifts 16-bit frames out on SCLK falls. Each frame's
// expected samples go into a scoreboard queue when the conversion is
// requested, and they are popped and compared whenever the DUT strobes valid.
// -----------------------------------------------------------------------------
module tb_pmod_ad1_reader;

    localparam int D = 4;
    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sdata_a = 1'b0;
    logic        sdata_b = 1'b0;
    logic        o_cs, o_sclk, o_valid, o_busy, o_err;
    logic [11:0] o_data_out_a, o_data_out_b;

    always #5 clk = ~clk;

    pmod_ad1_reader #(.CLK_DIV(D), .QUIET_CYC(Q)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_sdata_a    (sdata_a),
        .i_sdata_b    (sdata_b),
        .o_cs         (o_cs),
        .o_sclk       (o_sclk),
        .o_data_out_a (o_data_out_a),
        .o_data_out_b (o_data_out_b),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [11:0] exp_a;
        logic [11:0] exp_b;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } word_t;

    exp_t  sb[$];
    word_t model_q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    valid_count = 0;
    int    cs_falls = 0;
    logic  mon_prev_cs = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic err_exp(input logic e);
`ifdef PMOD_AD1_LEADZERO_CHECK_EN
        return e;
`else
        return 1'b0 & e;
`endif
    endfunction

    // ADC model: loads the next frame word at the CS fall and presents one bit
    // per SCLK fall, MSB first.
    logic [15:0] cur_a = '0;
    logic [15:0] cur_b = '0;
    int          bit_idx = -1;

    always @(negedge o_cs) begin : model_load
        word_t w;
        if (model_q.size() > 0) begin
            w = model_q.pop_front();
            cur_a = w.a;
            cur_b = w.b;
        end else begin
            cur_a = '0;
            cur_b = '0;
        end
        bit_idx = 15;
    end

    always @(negedge o_sclk) begin
        if (o_cs === 1'b0 && bit_idx >= 0) begin
            sdata_a = cur_a[bit_idx];
            sdata_b = cur_b[bit_idx];
            bit_idx--;
        end
    end

    // Output monitor: scoreboard compare on every valid strobe, CS fall count.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_valid === 1'b1) begin
            valid_count++;
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'd0, o_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_data_a", {20'd0, o_data_out_a}, {20'd0, e.a});
                check("sb_data_b", {20'd0, o_data_out_b}, {20'd0, e.b});
                check("sb_err", {31'd0, o_err}, {31'd0, e.err});
            end
        end
        if (mon_prev_cs === 1'b1 && o_cs === 1'b0) cs_falls++;
        mon_prev_cs = o_cs;
    end

    task automatic push_frame(input logic [15:0] a, input logic [15:0] b,
                              input logic [11:0] ea, input logic [11:0] eb, input logic ee);
        word_t w;
        exp_t  e;
        w.a = a; w.b = b;
        e.a = ea; e.b = eb; e.err = err_exp(ee);
        model_q.push_back(w);
        sb.push_back(e);
    endtask

    task automatic run_frame(input string name);
        int v0;
        int n;
        v0 = valid_count;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (o_busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy_timeout"}, {31'd0, o_busy}, 32'd0);
        check({name, "_valid_pulses"}, valid_count - v0, 32'd1);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_cs"},     {31'd0, o_cs},     32'd1);
        check({name, "_sclk"},   {31'd0, o_sclk},   32'd1);
        check({name, "_valid"},  {31'd0, o_valid},  32'd0);
        check({name, "_busy"},   {31'd0, o_busy},   32'd0);
        check({name, "_err"},    {31'd0, o_err},    32'd0);
        check({name, "_data_a"}, {20'd0, o_data_out_a}, 32'd0);
        check({name, "_data_b"}, {20'd0, o_data_out_b}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        int cs_bad, sclk_bad, valid_bad, busy_bad;
        int rises[$];
        int falls[$];
        logic prev;
        logic exp_bit;
        int v0, f0;

        vecs[0] = '{16'h0A5C, 16'h03F1, 12'hA5C, 12'h3F1, 1'b0};
        vecs[1] = '{16'h0000, 16'h0FFF, 12'h000, 12'hFFF, 1'b0};
        vecs[2] = '{16'h8123, 16'h0456, 12'h123, 12'h456, 1'b1};
        vecs[3] = '{16'h0FFF, 16'h0000, 12'hFFF, 12'h000, 1'b0};
        vecs[4] = '{16'h0555, 16'hF2AA, 12'h555, 12'h2AA, 1'b1};
        vecs[5] = '{16'h0001, 16'h0800, 12'h001, 12'h800, 1'b0};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single conversion with cycle-exact waveform checks; t counts the
        // rising edges since start was raised.
        push_frame(16'h0A5C, 16'h03F1, 12'hA5C, 12'h3F1, 1'b0);
        cs_bad = 0; sclk_bad = 0; valid_bad = 0; busy_bad = 0;
        prev = 1'b1;
        start = 1'b1;
        for (int t = 1; t <= 136; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
            exp_bit = (t < 130) ? 1'b0 : 1'b1;
            if (o_cs !== exp_bit) cs_bad++;
            exp_bit = (t < 129) ? ((((t - 1) / D) % 2) == 0) : 1'b1;
            if (o_sclk !== exp_bit) sclk_bad++;
            exp_bit = (t == 130);
            if (o_valid !== exp_bit) valid_bad++;
            exp_bit = (t < 134);
            if (o_busy !== exp_bit) busy_bad++;
            if (o_sclk === 1'b1 && prev === 1'b0) rises.push_back(t);
            prev = o_sclk;
        end
        check("frame_cs_wrong_cycles", cs_bad, 32'd0);
        check("frame_sclk_wrong_cycles", sclk_bad, 32'd0);
        check("frame_valid_wrong_cycles", valid_bad, 32'd0);
        check("frame_busy_wrong_cycles", busy_bad, 32'd0);
        check("frame_sclk_rise_count", rises.size(), 32'd16);
        for (int k = 0; k < 16 && k < rises.size(); k++)
            check($sformatf("frame_rise%0d_edge", k + 1), rises[k], 32'(9 + 8 * k));

        // Table-driven conversions.
        for (int i = 0; i < 6; i++) begin
            push_frame(vecs[i].a, vecs[i].b, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_err);
            run_frame($sformatf("vec%0d", i));
            check($sformatf("vec%0d_hold_a", i), {20'd0, o_data_out_a}, {20'd0, vecs[i].exp_a});
        end

        // Start held high: back-to-back frames.
        push_frame(16'h0000, 16'h0FFF, 12'h000, 12'hFFF, 1'b0);
        push_frame(16'h0FFF, 16'h0000, 12'hFFF, 12'h000, 1'b0);
        push_frame(16'h0800, 16'h0ABC, 12'h800, 12'hABC, 1'b0);
        v0 = valid_count;
        prev = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int t = 1; t <= 420; t++) begin
            @(negedge clk);
            if (t == 300) start = 1'b0;
            if (prev === 1'b1 && o_cs === 1'b0) falls.push_back(t);
            prev = o_cs;
        end
        check("b2b_cs_fall_count", falls.size(), 32'd3);
        if (falls.size() >= 3) begin
            check("b2b_fall1", falls[0], 32'd1);
            check("b2b_fall2", falls[1], 32'd135);
            check("b2b_fall3", falls[2], 32'd269);
        end
        check("b2b_valid_pulses", valid_count - v0, 32'd3);

        // Reset in the middle of a frame.
        push_frame(16'h0F0F, 16'h0777, 12'hF0F, 12'h777, 1'b0);
        @(negedge clk);
        start = 1'b1;
        for (int t = 1; t <= 59; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        sb.delete();
        model_q.delete();
        v0 = valid_count;
        repeat (150) @(negedge clk);
        check("midrst_no_valid", valid_count - v0, 32'd0);
        push_frame(16'h0C3A, 16'h0BEE, 12'hC3A, 12'hBEE, 1'b0);
        run_frame("after_rst");

        // Start pulses during SHIFT and QUIET are ignored.
        push_frame(16'h0246, 16'h0135, 12'h246, 12'h135, 1'b0);
        v0 = valid_count;
        f0 = cs_falls;
        @(negedge clk);
        start = 1'b1;
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            if (t == 1 || t == 51 || t == 133) start = 1'b0;
            if (t == 50 || t == 132) start = 1'b1;
        end
        check("ignored_valid_pulses", valid_count - v0, 32'd1);
        check("ignored_cs_frames", cs_falls - f0, 32'd1);
        check("ignored_sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmod_ad1_reader.md
# pmod_ad1_reader

Serial-capture master for the dual-channel 12-bit PmodAD1 ADC (two AD7476A-class converters sharing CS and SCLK). It is the input-side counterpart of the PmodDA2 DAC driver. On each `start` it generates one CS/SCLK frame of 16 SCLK periods and shifts both data lines in, MSB first. It then presents both 12-bit samples with a one-cycle valid strobe. It sits between the Pmod pins and the sample-processing logic in the video/acquisition design.

## Interface
- `CLK_DIV`, 4: SCLK half-period in `clk` cycles; legal range 2..255.
- `QUIET_CYC`, 4: minimum `clk` cycles in which `busy` stays high after CS rises (converter quiet time); legal range 1..255.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `SDATA_A`, `SDATA_B`  in  1 each  serial data from ADC channels A and B.
- `CS`  out  1  chip select, active low; reset 1.
- `SCLK`  out  1  serial clock, idles high; reset 1.
- `data_out_A`, `data_out_B`  out  12 each  last captured samples; reset 0.
- `valid`  out  1  one-cycle strobe when data_out_* update; reset 0.
- `busy`  out  1  high from the cycle after `start` is accepted until quiet time ends; reset 0.
- `err`  out  1  leading-zero violation flag (see Configuration); reset 0.

## Operation
- States: IDLE, SHIFT, QUIET.
- IDLE: CS=1, SCLK=1, busy=0.
  - `start`=1 -> SHIFT: CS<=0, busy<=1, bit counter<=0, divider<=0.
- SHIFT: SCLK toggles every CLK_DIV cycles, starting high. The first toggle is a fall.
  - On the clk edge that drives SCLK 0->1, sample SDATA_A/B into 16-bit shift registers (shift left, new bit at LSB) and increment the bit counter.
  - After the 16th rising edge, SCLK stays high. On the next edge: CS<=1, data_out_A/B <= shift[11:0], valid<=1, go to QUIET.
- Frame format: bits 15..12 are leading zeros; bits 11..0 are data, MSB first.
- QUIET: count QUIET_CYC cycles with busy=1 and CS=1, then go to IDLE (busy<=0).
- `start` is ignored outside IDLE; it is never queued. Holding `start` high gives back-to-back conversions.
- `rst` has priority at every state. Next edge: IDLE, all outputs at reset values, shift registers cleared, no valid for the aborted frame.
- data_out_* hold their value between valid strobes.

## Timing
- `start` sampled at edge 0 -> CS low at edge 1.
  - k-th SCLK fall at 1+(2k-1)·CLK_DIV.
  - k-th SCLK rise/sample at 1+2k·CLK_DIV (k=1..16).
- CS high, valid and data update at edge 2+32·CLK_DIV. With defaults that is 130.
- CS low width = 32·CLK_DIV+1 cycles.
- CS high between frames (start held) = QUIET_CYC+1 cycles. Default period = 134 cycles.
- busy falls at edge 2+32·CLK_DIV+QUIET_CYC.
- valid is exactly one cycle wide.
- SDATA is sampled CLK_DIV cycles after the preceding SCLK fall. No input synchronizer is included.

## Configuration
- `PMOD_AD1_LEADZERO_CHECK_EN` defined:
  - `err` is set with `valid` if any of bits 15..12 on either channel was 1.
  - `err` is cleared with the next `valid` whose leading bits are all 0, or by `rst`.
  - data_out_* update regardless.
- Undefined: no check logic is built; `err` is tied to 0.

## Test plan
- Reset -> CS=1, SCLK=1, valid=0, busy=0, err=0, data_out_A=data_out_B=0x000. Assert rst mid-run and repeat the checks.
- Single conversion, models drive A=0x0A5C, B=0x03F1 frames (defaults):
  - CS low at edge 1;
  - 16 SCLK rises at 9,17,…,129;
  - valid=1 only at edge 130 with data_out_A=0xA5C, data_out_B=0x3F1;
  - busy low at 134.
- `start` held high for 3 frames -> CS falls at 1, 135, 269; three valid pulses; data tracks a changing model pattern (0x000, 0xFFF, 0x800).
- rst pulsed at edge 60 of a frame -> CS=1, SCLK=1 next edge; no valid; data_out=0; a following start yields a correct full frame.
- With PMOD_AD1_LEADZERO_CHECK_EN: model drives A=0x8123 -> err=1 at valid, data_out_A=0x123. Next clean frame -> err=0.
- `start` pulses during SHIFT and QUIET -> ignored: exactly one frame, one valid.
